// File: rtl/ex_div_unit_pkg.sv
// Shared op codes and divider state encodings for the EX-stage divide unit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ex_div_unit_pkg;

  // Op codes produced by the ID-stage 3R decoder
  localparam logic [7:0] OP_DIV     = 8'h30;
  localparam logic [7:0] OP_MOD     = 8'h31;
  localparam logic [7:0] OP_DIVU    = 8'h32;
  localparam logic [7:0] OP_MODU    = 8'h33;
  localparam logic [7:0] OP_INVALID = 8'hFF;

  // Divider FSM states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // True for the four codes the divider actually computes
  function automatic logic is_div_op(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_MOD) || (op == OP_DIVU) || (op == OP_MODU);
  endfunction

endpackage

// File: rtl/ex_div_unit_div_iter_step.sv
// One radix-2 restoring divide step: shift {rem, quo} left, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Partial remainder gains the dividend MSB; XLEN+1 bits so the subtract sign is visible
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[XLEN-1:0];
      quo_nxt = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative 32-bit signed/unsigned divider (quotient or remainder) for the EX stage.
// Latency: accept at T, result at T+33; zero divisor / non-divide op / early-out at T+1.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional DIV_EARLY_OUT_EN.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  div_state_t      state_q, state_d;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, result_q;
  logic [5:0]      cnt_q;
  logic            sel_rem_q, quo_neg_q, rem_neg_q;

  logic            accept, is_signed, sel_rem, neg1, neg2, early, short_path;
  logic [XLEN-1:0] mag1, mag2, short_result;
  logic [XLEN-1:0] rem_nxt, quo_nxt, quo_fix, rem_fix, final_result;

  assign in_ready  = (state_q == DIV_IDLE);
  assign out_valid = (state_q == DIV_DONE);
  assign busy      = (state_q != DIV_IDLE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready && !flush;

  // Decode the incoming op, take operand magnitudes and pick the single-cycle result
  always_comb begin
    is_signed = (op == OP_DIV) || (op == OP_MOD);
    sel_rem   = (op == OP_MOD) || (op == OP_MODU);
    neg1      = is_signed && src1[XLEN-1];
    neg2      = is_signed && src2[XLEN-1];
    mag1      = neg1 ? -src1 : src1;
    mag2      = neg2 ? -src2 : src2;
`ifdef DIV_EARLY_OUT_EN
    early     = (mag1 < mag2);
`else
    early     = 1'b0;
`endif
    short_path = !is_div_op(op) || (src2 == '0) || early;
    if (!is_div_op(op))      short_result = '0;
    else if (src2 == '0)     short_result = sel_rem ? src1 : '1;
    else                     short_result = sel_rem ? src1 : '0;
  end

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Sign fix-up applied to the last iteration's output as it is registered
  always_comb begin
    quo_fix      = quo_neg_q ? -quo_nxt : quo_nxt;
    rem_fix      = rem_neg_q ? -rem_nxt : rem_nxt;
    final_result = sel_rem_q ? rem_fix : quo_fix;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= DIV_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (accept) state_d = short_path ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == 6'd1) state_d = DIV_DONE;
      DIV_DONE: if (out_ready) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  // Operand latch on accept, one restoring step per CALC cycle, result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      sel_rem_q <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (accept) begin
      rem_q     <= '0;
      quo_q     <= mag1;
      dvs_q     <= mag2;
      cnt_q     <= 6'(XLEN);
      sel_rem_q <= sel_rem;
      quo_neg_q <= neg1 ^ neg2;
      rem_neg_q <= neg1;
      if (short_path) result_q <= short_result;
    end else if (state_q == DIV_CALC && !flush) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - 6'd1;
      if (cnt_q == 6'd1) result_q <= final_result;
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed corner cases plus random ops vs an arithmetic model.
// Latency: checks 33-cycle and 1-cycle completion (early-out follows DIV_EARLY_OUT_EN).
// Backpressure: exercises out_ready stalls, flush and mid-operation reset.
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [7:0]  op;
  logic [31:0] src1, src2, result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_sgn(input logic [7:0] o);
    return (o == OP_DIV) || (o == OP_MOD);
  endfunction

  function automatic bit is_rem(input logic [7:0] o);
    return (o == OP_MOD) || (o == OP_MODU);
  endfunction

  function automatic bit is_dv(input logic [7:0] o);
    return (o == OP_DIV) || (o == OP_MOD) || (o == OP_DIVU) || (o == OP_MODU);
  endfunction

  // Architectural result from plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (!is_dv(o)) return 32'h0;
    if (b == 32'h0) return is_rem(o) ? a : 32'hFFFF_FFFF;
    if (is_sgn(o)) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem(o) ? 32'h0 : 32'h8000_0000;
      return is_rem(o) ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem(o) ? a % b : a / b;
  endfunction

  // Cycles from accept to first out_valid
  function automatic int ref_latency(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = (is_sgn(o) && a[31]) ? (64'sd4294967296 - longint'(a)) : longint'(a);
    mb = (is_sgn(o) && b[31]) ? (64'sd4294967296 - longint'(b)) : longint'(b);
    if (!is_dv(o) || b == 32'h0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return 33;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one op, wait for completion, optionally stall the result for 'stall' cycles
  task automatic run_div(input string tag, input logic [7:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int stall);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    out_ready = (stall == 0);
    in_valid = 1'b1;
    op = o;
    src1 = a;
    src2 = b;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = OP_INVALID;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(ref_latency(o, a, b)));
    chk({tag, ".result"}, result, ref_result(o, a, b));
    if (lat >= 60) begin
      do_reset();
      return;
    end
    held = result;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, ".stall_valid"}, 32'(out_valid), 32'h1);
      chk({tag, ".stall_result"}, result, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".drained"}, 32'(out_valid), 32'h0);
    chk({tag, ".idle"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    logic [7:0] ops [5];
    logic [7:0] o;
    logic [31:0] a, b;
    int seen;

    ops[0] = OP_DIV; ops[1] = OP_MOD; ops[2] = OP_DIVU; ops[3] = OP_MODU; ops[4] = OP_INVALID;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_INVALID; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.result", result, 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.in_ready", 32'(in_ready), 32'h1);

    // Directed cases
    run_div("div_100_7",  OP_DIV,  32'd100,        32'd7,          0);
    run_div("mod_m100_7", OP_MOD,  32'hFFFF_FF9C,  32'd7,          0);
    run_div("divu_max_2", OP_DIVU, 32'hFFFF_FFFF,  32'd2,          0);
    run_div("modu_max_2", OP_MODU, 32'hFFFF_FFFF,  32'd2,          0);
    run_div("div_ovf",    OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  0);
    run_div("mod_ovf",    OP_MOD,  32'h8000_0000,  32'hFFFF_FFFF,  0);
    run_div("div_5_0",    OP_DIV,  32'd5,          32'd0,          0);
    run_div("modu_5_0",   OP_MODU, 32'd5,          32'd0,          0);
    run_div("mod_m7_0",   OP_MOD,  32'hFFFF_FFF9,  32'd0,          0);
    run_div("invalid_op", OP_INVALID, 32'd50,      32'd3,          0);
    run_div("divu_3_9",   OP_DIVU, 32'd3,          32'd9,          0);
    run_div("mod_7_m3",   OP_MOD,  32'd7,          32'hFFFF_FFFD,  0);

    // Flush in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIV; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush.busy_calc", 32'(busy), 32'h1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.in_ready", 32'(in_ready), 32'h1);
    chk("flush.out_valid", 32'(out_valid), 32'h0);
    chk("flush.busy", 32'(busy), 32'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush.no_output", 32'(seen), 32'h0);
    run_div("post_flush", OP_DIVU, 32'd1000, 32'd3, 0);

    // Result held while downstream stalls
    run_div("stall5", OP_DIV, 32'hFFFF_FC18, 32'd7, 5);

    // Reset in the middle of a divide clears everything
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIVU; src1 = 32'd77; src2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst.in_ready", 32'(in_ready), 32'h1);
    chk("midrst.busy", 32'(busy), 32'h0);
    chk("midrst.result", result, 32'h0);
    chk("midrst.out_valid", 32'(out_valid), 32'h0);

    // Random ops against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      o = ops[$urandom_range(0, 4)];
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        3: begin b = $urandom; a = $urandom_range(0, 100); end
        default: b = $urandom;
      endcase
      run_div("rand", o, a, b, (n % 8 == 3) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
